// File: rtl/ber_pkg.sv
// Shared types and helpers for the BER meter: FSM states, symbol width, bit counting.
package ber_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_MEASURE,
        ST_DONE
    } ber_state_t;

    localparam int SYM_W = 4;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/sym_delay_line.sv
// Reference symbol shift register; tap 0 is the live input, tap d is d strobes old.
module sym_delay_line
    import ber_pkg::*;
#(
    parameter int MAX_DELAY = 32,
    parameter int SEL_W     = $clog2(MAX_DELAY)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sym_clk_ena,
    input  logic [SYM_W-1:0] din,
    input  logic [SEL_W-1:0] sel,
    output logic [SYM_W-1:0] tap
);

    logic [SYM_W*(MAX_DELAY-1)-1:0] sr;
    logic [SYM_W*MAX_DELAY-1:0]     taps;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else if (sym_clk_ena) begin
            sr <= {sr[SYM_W*(MAX_DELAY-2)-1:0], din};
        end
    end

    // Live input sits at the bottom so tap index equals delay in strobes.
    assign taps = {sr, din};
    assign tap  = taps[sel*SYM_W +: SYM_W];

endmodule

// File: rtl/ber_meter.sv
// Symbol latency search followed by windowed bit/symbol error counting.
//   state      | meaning
//   ST_IDLE    | waiting for start; delay line still shifts
//   ST_SEARCH  | stepping delay_sel until LOCK_SYMS consecutive matches
//   ST_MEASURE | accumulating errors over 2^WINDOW_LOG2 symbols
//   ST_DONE    | holding last window results until start
module ber_meter
    import ber_pkg::*;
#(
    parameter int MAX_DELAY   = 32,
    parameter int LOCK_SYMS   = 64,
    parameter int WINDOW_LOG2 = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sym_clk_ena,
    input  logic [1:0]                   ref_i,
    input  logic [1:0]                   ref_q,
    input  logic [1:0]                   rx_i,
    input  logic [1:0]                   rx_q,
    input  logic                         start,
    input  logic                         clear,
    output logic                         locked,
    output logic [$clog2(MAX_DELAY)-1:0] delay_sel,
    output logic                         busy,
    output logic                         done,
    output logic                         no_lock,
    output logic [WINDOW_LOG2+2:0]       bit_errors,
    output logic [WINDOW_LOG2:0]         sym_errors
);

    localparam int DW = $clog2(MAX_DELAY);
    localparam int RW = $clog2(LOCK_SYMS + 1);
    localparam int CW = WINDOW_LOG2 + 1;
    localparam int BW = WINDOW_LOG2 + 3;

    ber_state_t       state, state_next;
    logic [SYM_W-1:0] tap, err;
    logic             err_any, lock_hit, win_end;
    logic [RW-1:0]    run, run_inc;
    logic [CW-1:0]    sym_cnt, cnt_inc;
    logic [BW-1:0]    bit_acc, bit_acc_next;
    logic [CW-1:0]    sym_acc, sym_acc_next;

    sym_delay_line #(.MAX_DELAY(MAX_DELAY)) u_dline (
        .clk         (clk),
        .reset       (reset),
        .sym_clk_ena (sym_clk_ena),
        .din         ({ref_i, ref_q}),
        .sel         (delay_sel),
        .tap         (tap)
    );

    assign err          = tap ^ {rx_i, rx_q};
    assign err_any      = |err;
    assign run_inc      = run + RW'(1);
    assign cnt_inc      = sym_cnt + CW'(1);
    assign bit_acc_next = bit_acc + BW'(popcount4(err));
    assign sym_acc_next = sym_acc + CW'(err_any);
    assign lock_hit     = sym_clk_ena && !err_any && (run_inc == RW'(LOCK_SYMS));
    assign win_end      = sym_clk_ena && (cnt_inc == CW'(2 ** WINDOW_LOG2));
    assign busy         = (state == ST_SEARCH) || (state == ST_MEASURE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (start)    state_next = locked ? ST_MEASURE : ST_SEARCH;
                ST_SEARCH:  if (lock_hit) state_next = ST_MEASURE;
                ST_MEASURE: if (win_end)  state_next = ST_DONE;
                ST_DONE:    if (start)    state_next = ST_MEASURE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            locked     <= 1'b0;
            delay_sel  <= '0;
            done       <= 1'b0;
            no_lock    <= 1'b0;
            bit_errors <= '0;
            sym_errors <= '0;
            run        <= '0;
            sym_cnt    <= '0;
            bit_acc    <= '0;
            sym_acc    <= '0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                locked     <= 1'b0;
                delay_sel  <= '0;
                no_lock    <= 1'b0;
                bit_errors <= '0;
                sym_errors <= '0;
                run        <= '0;
                sym_cnt    <= '0;
                bit_acc    <= '0;
                sym_acc    <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            run     <= '0;
                            sym_cnt <= '0;
                            bit_acc <= '0;
                            sym_acc <= '0;
                            if (!locked) delay_sel <= '0;
                        end
                    end
                    ST_SEARCH: begin
                        if (sym_clk_ena) begin
                            if (lock_hit) begin
                                locked  <= 1'b1;
                                run     <= '0;
                                sym_cnt <= '0;
                                bit_acc <= '0;
                                sym_acc <= '0;
                            end else if (!err_any) begin
                                run <= run_inc;
                            end else begin
                                run <= '0;
                                // A wrap means every candidate delay has failed at least once.
                                if (delay_sel == DW'(MAX_DELAY - 1)) begin
                                    delay_sel <= '0;
                                    no_lock   <= 1'b1;
                                end else begin
                                    delay_sel <= delay_sel + DW'(1);
                                end
                            end
                        end
                    end
                    ST_MEASURE: begin
                        if (sym_clk_ena) begin
                            sym_cnt <= cnt_inc;
                            bit_acc <= bit_acc_next;
                            sym_acc <= sym_acc_next;
                            if (win_end) begin
                                bit_errors <= bit_acc_next;
                                sym_errors <= sym_acc_next;
                                done       <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (start) begin
                            sym_cnt <= '0;
                            bit_acc <= '0;
                            sym_acc <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ber_meter.sv
// Directed bench for ber_meter: window results go through a scoreboard queue, search tracked by a small model.
module tb_ber_meter;

    localparam int MAXD = 32;
    localparam int LOCK = 8;
    localparam int WLOG = 4;

    logic       clk = 1'b0;
    logic       reset, sym_clk_ena, start, clear;
    logic [1:0] ref_i, ref_q, rx_i, rx_q;
    logic       locked, busy, done, no_lock;
    logic [4:0] delay_sel;
    logic [6:0] bit_errors;
    logic [4:0] sym_errors;

    int checks = 0;
    int failures = 0;
    int exp_bits[$];
    int exp_syms[$];

    logic [15:0] lfsr = 16'hACE1;
    logic [3:0]  hist [MAXD];
    int          rx_delay = 5;
    bit          rx_zero = 1'b0;
    bit          injected = 1'b0;

    int m_state, m_run, m_delay, m_cnt;
    bit m_locked, m_nolock;

    ber_meter #(.MAX_DELAY(MAXD), .LOCK_SYMS(LOCK), .WINDOW_LOG2(WLOG)) dut (
        .clk(clk), .reset(reset), .sym_clk_ena(sym_clk_ena),
        .ref_i(ref_i), .ref_q(ref_q), .rx_i(rx_i), .rx_q(rx_q),
        .start(start), .clear(clear), .locked(locked), .delay_sel(delay_sel),
        .busy(busy), .done(done), .no_lock(no_lock),
        .bit_errors(bit_errors), .sym_errors(sym_errors)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (exp_bits.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected done=0");
            end else begin
                check("win_bit_errors", bit_errors, exp_bits.pop_front());
                check("win_sym_errors", sym_errors, exp_syms.pop_front());
            end
        end
    end

    task automatic model_reset(input bit clr_hist);
        m_state = 0; m_run = 0; m_delay = 0; m_cnt = 0;
        m_locked = 1'b0; m_nolock = 1'b0;
        if (clr_hist) for (int k = 0; k < MAXD; k++) hist[k] = 4'h0;
    endtask

    task automatic model_step(input logic [3:0] e);
        if (m_state == 1) begin
            if (e == 4'h0) begin
                m_run++;
                if (m_run == LOCK) begin
                    m_locked = 1'b1; m_state = 2; m_cnt = 0; m_run = 0;
                end
            end else begin
                m_run = 0;
                if (m_delay == MAXD - 1) begin
                    m_delay = 0; m_nolock = 1'b1;
                end else m_delay++;
            end
        end else if (m_state == 2) begin
            m_cnt++;
            if (m_cnt == 2 ** WLOG) m_state = 3;
        end
    endtask

    task automatic gen_ref(output logic [3:0] s);
        for (int k = 0; k < 4; k++) lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        s = lfsr[3:0];
    endtask

    task automatic sym_step(input logic [3:0] flip);
        logic [3:0] s, rxs;
        for (int k = MAXD - 1; k > 0; k--) hist[k] = hist[k-1];
        gen_ref(s);
        hist[0] = s;
        rxs = rx_zero ? 4'h0 : (hist[rx_delay] ^ flip);
        @(negedge clk);
        {ref_i, ref_q} = hist[0];
        {rx_i, rx_q}   = rxs;
        sym_clk_ena    = 1'b1;
        model_step(rxs ^ hist[m_delay]);
        @(negedge clk);
        sym_clk_ena = 1'b0;
        check("step_delay_sel", delay_sel, m_delay);
        check("step_locked", locked, m_locked);
        check("step_no_lock", no_lock, m_nolock);
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        if (m_state == 0) begin
            m_state = m_locked ? 2 : 1;
            if (!m_locked) m_delay = 0;
            m_run = 0; m_cnt = 0;
        end else if (m_state == 3) begin
            m_state = 2; m_cnt = 0;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_clear(input bit with_start);
        @(negedge clk);
        clear = 1'b1;
        start = with_start;
        model_reset(1'b0);
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
    endtask

    task automatic search(input int budget, input bit inject);
        for (int n = 0; n < budget && !m_locked; n++) begin
            if (inject && !injected && m_state == 1 && m_delay == 5 && m_run == 7) begin
                injected = 1'b1;
                sym_step(4'hF);
                check("err_advance_delay", delay_sel, 6);
            end else begin
                sym_step(4'h0);
            end
        end
        check("lock_locked", locked, 1);
        check("lock_delay", delay_sel, 5);
        check("lock_busy", busy, 1);
    endtask

    task automatic run_window(input bit flips, input int eb, input int es);
        exp_bits.push_back(eb);
        exp_syms.push_back(es);
        for (int s = 0; s < 2 ** WLOG; s++) begin
            if (flips && s == 3)       sym_step(4'b0100);
            else if (flips && s == 7)  sym_step(4'b0010);
            else if (flips && s == 11) sym_step(4'b1111);
            else                       sym_step(4'b0000);
        end
        check("window_done_state", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_delay_sel"}, delay_sel, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_no_lock"}, no_lock, 0);
        check({tag, "_bit_errors"}, bit_errors, 0);
        check({tag, "_sym_errors"}, sym_errors, 0);
    endtask

    initial begin
        reset = 1'b0; sym_clk_ena = 1'b0; start = 1'b0; clear = 1'b0;
        ref_i = 2'b00; ref_q = 2'b00; rx_i = 2'b00; rx_q = 2'b00;
        model_reset(1'b1);
        repeat (3) @(negedge clk);
        check_all_zero("por");
        reset = 1'b1;

        // Lock at delay 5, clean window, then a flipped window restarted without search.
        repeat (40) sym_step(4'h0);
        pulse_start();
        search(400, 1'b0);
        run_window(1'b0, 0, 0);
        pulse_start();
        check("restart_busy", busy, 1);
        check("restart_delay", delay_sel, 5);
        run_window(1'b1, 6, 3);

        // Clear mid-window at symbol 10, then start+clear together.
        pulse_start();
        repeat (10) sym_step(4'h0);
        pulse_clear(1'b0);
        check_all_zero("clear");
        repeat (10) sym_step(4'h0);
        pulse_clear(1'b1);
        check("start_clear_busy", busy, 0);
        repeat (3) sym_step(4'h0);
        check("start_clear_idle", busy, 0);

        // Error at run 7 forces a full sweep before relocking at 5.
        pulse_start();
        search(600, 1'b1);
        check("relock_no_lock", no_lock, 1);
        run_window(1'b1, 6, 3);

        // Reset in the middle of a window.
        pulse_start();
        repeat (5) sym_step(4'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        model_reset(1'b1);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) sym_step(4'h0);
        check("post_reset_busy", busy, 0);

        // Receiver stuck at zero never locks; the sweep wraps and sets no_lock.
        rx_zero = 1'b1;
        pulse_start();
        repeat (60) sym_step(4'h0);
        check("stuck_locked", locked, 0);
        check("stuck_no_lock", no_lock, 1);
        check("stuck_busy", busy, 1);

        repeat (4) @(negedge clk);
        check("pending_windows", exp_bits.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
